regfile: RTL and testbench

//  32 x 32-bit register file: two combinational read ports, one clocked write port.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/register_w.sv | 24 ++
 rtl/regfile.sv | 51 +++++
 tb/tb_regfile.sv | 132 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, types and the read-side mux tree for the 32 x 32 register file.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [DATA_W-1:0]                 word_t;
  typedef logic [ADDR_W-1:0]                 reg_idx_t;
  typedef logic [NUM_REGS-1:0][DATA_W-1:0]   reg_bank_t;

  // Binary 2:1 mux tree, one select bit per level (LSB first). The reduction is
  // done in place: slot j is written only after slots 2j and 2j+1 are consumed.
  function automatic word_t mux_tree(input reg_bank_t v, input reg_idx_t sel);
    reg_bank_t t;
    t = v;
    for (int l = 0; l < ADDR_W; l++)
      for (int j = 0; j < (NUM_REGS >> (l + 1)); j++)
        t[j] = sel[l] ? t[2*j+1] : t[2*j];
    return t[0];
  endfunction
endpackage

// File: rtl/register_w.sv
// One DATA_W-bit register with write enable and synchronous reset.
module register_w
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  word_t q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/regfile.sv
// 32 x 32 register file: one clocked write port, two combinational read ports,
// register 0 hardwired to zero.
module regfile
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  logic [3:0]            dec_hi;
  logic [7:0]            dec_lo;
  logic [NUM_REGS-1:1]   wr_en;
  reg_bank_t             regs;

  // Two-level decode: 2:4 on the upper index bits, 3:8 on the lower, ANDed
  // together with RegWrite. Entry 0 has no enable, so writes to it vanish.
  always_comb begin
    dec_hi = '0;
    dec_lo = '0;
    wr_en  = '0;
    dec_hi[WriteRegister[4:3]] = 1'b1;
    dec_lo[WriteRegister[2:0]] = 1'b1;
    for (int h = 0; h < 4; h++)
      for (int l = 0; l < 8; l++)
        if ((h * 8 + l) != int'(ZERO_REG))
          wr_en[h*8+l] = RegWrite & dec_hi[h] & dec_lo[l];
  end

  assign regs[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    register_w u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en[i]),
      .d     (WriteData),
      .q     (regs[i])
    );
  end

  // No write-to-read bypass: reads see storage only, so a same-cycle write
  // becomes visible after the edge.
  assign ReadData1 = mux_tree(regs, ReadRegister1);
  assign ReadData2 = mux_tree(regs, ReadRegister2);
endmodule

// File: tb/tb_regfile.sv
// Directed scenarios plus random traffic against an array-based register model.
`timescale 1ps/1ps
module tb_regfile;
  logic        clk, reset, RegWrite;
  logic [4:0]  WriteRegister, ReadRegister1, ReadRegister2;
  logic [31:0] WriteData, ReadData1, ReadData2;

  int n_chk, n_fail;
  logic [31:0] model [32];

  regfile dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  initial begin
    clk = 1'b0;
    forever #2500 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Apply the model's view of the edge, then let the DUT take it.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (RegWrite && WriteRegister != 5'd0) begin
      model[WriteRegister] = WriteData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b);
    ReadRegister1 = a;
    ReadRegister2 = b;
    #10;
    chk({tag, "_p1"}, ReadData1, model[a]);
    chk({tag, "_p2"}, ReadData2, model[b]);
  endtask

  initial begin
    logic [31:0] k;
    n_chk = 0; n_fail = 0;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;

    // reset for two edges, every index reads zero on both ports
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      #10;
      chk("rst_p1", ReadData1, 32'h0);
      chk("rst_p2", ReadData2, 32'h0);
    end

    // write to register 0 is dropped
    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hA0;
    tick();
    RegWrite = 1'b0;
    ReadRegister1 = 5'd0; #10;
    chk("r0_write", ReadData1, 32'h0);

    // fill 1..31 with i*k and read back i and i-1
    k = 32'h01020408;
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = 32'(i) * k;
      tick();
      RegWrite = 1'b0;
      ReadRegister1 = 5'(i - 1); ReadRegister2 = 5'(i);
      #10;
      chk("fill_p2", ReadData2, 32'(i) * k);
      chk("fill_p1", ReadData1, 32'(i - 1) * k);
    end

    // disabled writes change nothing
    RegWrite = 1'b0; WriteRegister = 5'd5; WriteData = 32'hDEADBEEF;
    tick(); tick(); tick();
    ReadRegister1 = 5'd5; #10;
    chk("we_off", ReadData1, 32'h050A1428);

    // collision: old value before the edge, new value after
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'h12345678;
    ReadRegister1 = 5'd7; ReadRegister2 = 5'd7; #10;
    chk("coll_pre", ReadData1, 32'h070E1C38);
    tick();
    RegWrite = 1'b0; #10;
    chk("coll_post1", ReadData1, 32'h12345678);
    chk("coll_post2", ReadData2, 32'h12345678);

    // reset wins over a simultaneous write
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'hFFFFFFFF;
    tick();
    reset = 1'b0; RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(i); #10;
      chk("mrst_p1", ReadData1, 32'h0);
      chk("mrst_p2", ReadData2, 32'h0);
    end
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h3;
    tick();
    RegWrite = 1'b0;
    ReadRegister1 = 5'd3; #10;
    chk("post_rst_w", ReadData1, 32'h3);

    // random traffic, reads checked before each edge (old-value semantics)
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 49) == 0);
      RegWrite      = $urandom_range(0, 3) != 0;
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = $urandom;
      if ($urandom_range(0, 3) == 0) rd("rnd", WriteRegister, 5'($urandom_range(0, 31)));
      else rd("rnd", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
    end
    reset = 1'b0; RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) rd("final", 5'(i), 5'(31 - i));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
